div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for DIV/DIVU in the EX stage of the five-stage pipeline. Accepts operands from EX, runs a 32-iteration restoring division, and returns quotient and remainder for HI/LO writeback. While a division is in flight it raises `stallreq_o`, which EX forwards as its stall request to the pipeline controller. That request freezes IF/ID/EX until the result is ready.

---
 rtl/div_unit.sv | 151 +++++++++++++++
 tb/tb_div_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU in EX, result is {remainder, quotient}.
// Define DIV_BYZERO_FAST_EN to route zero divisors through BYZERO (result 0 two cycles after start).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_dvd_q, neg_dvd_d;
  logic               neg_dvs_q, neg_dvs_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [WIDTH:0]     trial, diff;
  logic               step_ok;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // One restoring step: the partial remainder stays below the divisor, so WIDTH+1 bits suffice.
  assign trial    = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs_q};
  assign step_ok  = ~diff[WIDTH];
  assign rem_step = step_ok ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step = {dvd_q[WIDTH-2:0], step_ok};

  assign quo_fix = (neg_dvd_q ^ neg_dvs_q) ? -quo_step : quo_step;
  assign rem_fix = neg_dvd_q ? -rem_step : rem_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    case (state_q)
      FREE: begin
        if (start_i && !annul_i) begin
          dvd_d     = op1_mag;
          dvs_d     = op2_mag;
          rem_d     = '0;
          neg_dvd_d = op1_neg;
          neg_dvs_d = op2_neg;
          cnt_d     = '0;
          state_d   = ON;
`ifdef DIV_BYZERO_FAST_EN
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end
`endif
        end
      end
`ifdef DIV_BYZERO_FAST_EN
      BYZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
`endif
      ON: begin
        if (annul_i) begin
          cnt_d   = '0;
          state_d = FREE;
        end else begin
          dvd_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 1'b1;
          // Last step: sign-correct and register so ready/result appear together in END.
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d    = '0;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
            state_d  = END;
          end
        end
      end
      END: begin
        state_d = FREE;
      end
      default: begin
        state_d = FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~annul_i & (state_q != END);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a cycle-level reference model and per-cycle compare.
// Expectations follow DIV_BYZERO_FAST_EN when it is defined for the build.
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           signed_div_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sb_en = 1'b0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .annul_i(annul_i),
    .result_o(result_o),
    .ready_o(ready_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (b == 32'd0) begin
`ifdef DIV_BYZERO_FAST_EN
      return 64'd0;
`else
      q = (sa < 0) ? -longint'(32'hFFFF_FFFF) : longint'(32'hFFFF_FFFF);
      r = sa;
`endif
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat_of(input logic [31:0] b);
`ifdef DIV_BYZERO_FAST_EN
    if (b == 32'd0) return 2;
`endif
    return 33;
  endfunction

  logic        m_busy = 1'b0;
  int          m_done = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_result = '0;
  logic        exp_ready, exp_stall;

  // Per-cycle compare against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    exp_ready = m_busy && (cyc == m_done);
    exp_stall = start_i && !annul_i && !exp_ready;
    if (exp_ready) m_result = m_pend;
    if (sb_en) begin
      checkOutput("sb_ready", {63'd0, ready_o}, {63'd0, exp_ready});
      checkOutput("sb_stall", {63'd0, stallreq_o}, {63'd0, exp_stall});
      checkOutput("sb_result", result_o, m_result);
    end
    if (rst) begin
      m_busy   = 1'b0;
      m_result = '0;
    end else if (exp_ready) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (annul_i) m_busy = 1'b0;
    end else if (start_i && !annul_i) begin
      m_busy = 1'b1;
      m_done = cyc + lat_of(opdata2_i);
      m_pend = ref_div(opdata1_i, opdata2_i, signed_div_i);
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               output int lat, output logic [63:0] res, output int rdy_cyc);
    int t0;
    bit seen;
    @(posedge clk);
    #1;
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    t0      = cyc;
    seen    = 1'b0;
    lat     = -1;
    res     = '0;
    rdy_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready_o) begin
        seen    = 1'b1;
        lat     = cyc - t0;
        res     = result_o;
        rdy_cyc = cyc;
      end else if (i == 1) begin
        opdata1_i = ~a;
        opdata2_i = a ^ b ^ 32'h1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout got=no_ready required=ready_within_40_cycles");
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    int lat, rc1, rc2, t0;
    logic [63:0] res, last_exp;
    bit seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_result", result_o, 64'd0);
    checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset_stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    sb_en = 1'b1;

    checkOutput("model_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    checkOutput("model_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
    checkOutput("model_min_m1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h00000000_80000000);

    applyStimulus(32'd100, 32'd7, 1'b0, lat, res, rc1);
    checkOutput("divu_100_7", res, 64'h00000002_0000000E);
    checkOutput("divu_100_7_lat", 64'(lat), 64'd33);
    applyStimulus(32'd9, 32'd3, 1'b0, lat, res, rc2);
    checkOutput("b2b_9_3", res, 64'h00000000_00000003);
    checkOutput("b2b_gap", 64'(rc2 - rc1), 64'd34);
    idle(3);

    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res, rc1);
    checkOutput("div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
    idle(2);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res, rc1);
    checkOutput("div_min_m1", res, 64'h00000000_80000000);
    idle(2);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, lat, res, rc1);
    checkOutput("div_7_m2", res, 64'h00000001_FFFFFFFD);
    idle(2);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, lat, res, rc1);
    checkOutput("divu_max_1", res, 64'h00000000_FFFFFFFF);
    idle(2);
    applyStimulus(32'd3, 32'd10, 1'b0, lat, res, rc1);
    checkOutput("divu_3_10", res, 64'h00000003_00000000);
    idle(2);

    applyStimulus(32'd5, 32'd0, 1'b0, lat, res, rc1);
`ifdef DIV_BYZERO_FAST_EN
    checkOutput("divu_5_0", res, 64'd0);
    checkOutput("divu_5_0_lat", 64'(lat), 64'd2);
`else
    checkOutput("divu_5_0", res, 64'h00000005_FFFFFFFF);
    checkOutput("divu_5_0_lat", 64'(lat), 64'd33);
`endif
    idle(2);
    applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b1, lat, res, rc1);
`ifdef DIV_BYZERO_FAST_EN
    last_exp = 64'd0;
`else
    last_exp = 64'hFFFFFFFB_00000001;
`endif
    checkOutput("div_m5_0", res, last_exp);
    idle(2);

    @(posedge clk);
    #1;
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul_cycle", 64'(cyc - t0), 64'd10);
    checkOutput("annul_stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    checkOutput("annul_no_ready", {63'd0, seen}, 64'd0);
    checkOutput("annul_result_held", result_o, last_exp);

    @(posedge clk);
    #1;
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd20; opdata2_i = 32'd4;
    @(posedge clk);
    #1;
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    repeat (36) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    checkOutput("annul_start_no_ready", {63'd0, seen}, 64'd0);
    checkOutput("annul_start_result_held", result_o, last_exp);

    @(posedge clk);
    #1;
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd50000; opdata2_i = 32'd7;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_result", result_o, 64'd0);
    checkOutput("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("rst_mid_stall", {63'd0, stallreq_o}, 64'd0);
    applyStimulus(32'd8, 32'd2, 1'b0, lat, res, rc1);
    checkOutput("divu_8_2", res, 64'h00000000_00000004);
    checkOutput("divu_8_2_lat", 64'(lat), 64'd33);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
